// File: rtl/axi_pkg.sv
// Shared AXI definitions for the bridge-facing SRAM slave: widths, burst/response
// encodings and the slave sequencing states.
package axi_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACC  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } slv_state_e;

  // WRAP and the reserved encoding behave like INCR; only FIXED holds the address.
  function automatic logic burst_advances(input logic [1:0] burst);
    logic adv;
    case (burst)
      BURST_FIXED:            adv = 1'b0;
      BURST_INCR, BURST_WRAP: adv = 1'b1;
      default:                adv = 1'b1;
    endcase
    return adv;
  endfunction

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Per-beat SRAM word address and beat counter, shared by the read and write
// paths since only one burst is ever in flight.
module axi_beat_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [AW-1:0]           i_start_addr,
  input  logic [1:0]              i_burst,
  input  logic                    i_advance,
  output logic [AW-1:0]           o_addr,
  output logic [AXI_LEN_BITS-1:0] o_cnt
);

  logic [AW-1:0]           r_addr;
  logic [AXI_LEN_BITS-1:0] r_cnt;
  logic [1:0]              r_burst;

  // Address wraps naturally modulo 2^AW.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= {AW{1'b0}};
      r_cnt   <= {AXI_LEN_BITS{1'b0}};
      r_burst <= BURST_FIXED;
    end else if (i_load) begin
      r_addr  <= i_start_addr;
      r_cnt   <= {AXI_LEN_BITS{1'b0}};
      r_burst <= i_burst;
    end else if (i_advance) begin
      r_cnt <= r_cnt + AXI_LEN_BITS'(1);
      if (burst_advances(r_burst)) begin
        r_addr <= r_addr + AW'(1);
      end
    end
  end

  assign o_addr = r_addr;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/sram_axi_slave.sv
// AXI4 slave wrapper turning bridge read/write bursts into single-port SRAM
// accesses; one burst at a time, read/write arbitration alternates.
module sram_axi_slave
  import axi_pkg::*;
#(
  parameter int SRAM_AW = 14,
  parameter int DATA_W  = AXI_DATA_BITS,
  parameter int IDS_W   = AXI_IDS_BITS
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [IDS_W-1:0]         AWID,
  input  logic [31:0]              AWADDR,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic [AXI_STRB_BITS-1:0] WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [IDS_W-1:0]         BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [IDS_W-1:0]         ARID,
  input  logic [31:0]              ARADDR,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [IDS_W-1:0]         RID,
  output logic [DATA_W-1:0]        RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic                     CEB,
  output logic [AXI_STRB_BITS-1:0] WEB,
  output logic [SRAM_AW-1:0]       A,
  output logic [DATA_W-1:0]        DI,
  input  logic [DATA_W-1:0]        DO
);

  slv_state_e              r_state;
  logic                    r_last_rd;
  logic                    r_rd_cap;
  logic                    r_err;
  logic [AXI_LEN_BITS-1:0] r_len;
  logic [IDS_W-1:0]        r_id;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_rvalid;
  logic                    r_rlast;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;

  logic                    w_ar_grant;
  logic                    w_aw_grant;
  logic                    w_last;
  logic                    w_wbeat;
  logic                    w_rhs;
  logic                    w_wlast_err;
  logic                    w_advance;
  logic [SRAM_AW-1:0]      w_addr;
  logic [SRAM_AW-1:0]      w_start_addr;
  logic [1:0]              w_burst;
  logic [AXI_LEN_BITS-1:0] w_cnt;
  logic                    w_unused;

  // last_rd=0 lets a pending read win a tie, last_rd=1 lets the write win.
  assign w_ar_grant   = (r_state == IDLE) && ARVALID && (!AWVALID || !r_last_rd);
  assign w_aw_grant   = (r_state == IDLE) && AWVALID && (!ARVALID || r_last_rd);
  assign w_start_addr = w_ar_grant ? ARADDR[SRAM_AW+1:2] : AWADDR[SRAM_AW+1:2];
  assign w_burst      = w_ar_grant ? ARBURST : AWBURST;

  assign w_last      = (w_cnt == r_len);
  assign w_wbeat     = (r_state == WR_DATA) && WVALID;
  assign w_rhs       = (r_state == RD_DATA) && r_rvalid && RREADY;
  assign w_wlast_err = (WLAST != w_last);
  assign w_advance   = (w_rhs || w_wbeat) && !w_last;

  assign w_unused = ^{AWSIZE, ARSIZE, AWADDR[31:SRAM_AW+2], AWADDR[1:0],
                      ARADDR[31:SRAM_AW+2], ARADDR[1:0]};

  axi_beat_addr_gen #(.AW(SRAM_AW)) u_addr_gen (
    .i_clk        (ACLK),
    .i_rst_n      (ARESETn),
    .i_load       (w_ar_grant || w_aw_grant),
    .i_start_addr (w_start_addr),
    .i_burst      (w_burst),
    .i_advance    (w_advance),
    .o_addr       (w_addr),
    .o_cnt        (w_cnt)
  );

  // Burst sequencing; RD_DATA first waits one cycle for DO before raising RVALID.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= IDLE;
      r_last_rd <= 1'b0;
      r_rd_cap  <= 1'b0;
      r_err     <= 1'b0;
      r_len     <= {AXI_LEN_BITS{1'b0}};
      r_id      <= {IDS_W{1'b0}};
      r_rdata   <= {DATA_W{1'b0}};
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ar_grant) begin
            r_id    <= ARID;
            r_len   <= ARLEN;
            r_state <= RD_ACC;
          end else if (w_aw_grant) begin
            r_id    <= AWID;
            r_len   <= AWLEN;
            r_err   <= 1'b0;
            r_state <= WR_DATA;
          end
        end
        RD_ACC: begin
          r_rd_cap <= 1'b1;
          r_state  <= RD_DATA;
        end
        RD_DATA: begin
          if (r_rd_cap) begin
            r_rdata  <= DO;
            r_rvalid <= 1'b1;
            r_rlast  <= w_last;
            r_rd_cap <= 1'b0;
          end else if (w_rhs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (w_last) begin
              r_last_rd <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_state <= RD_ACC;
            end
          end
        end
        WR_DATA: begin
          if (w_wbeat) begin
            if (w_wlast_err) begin
              r_err <= 1'b1;
            end
            if (w_last) begin
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err || w_wlast_err) ? RESP_SLVERR : RESP_OKAY;
              r_state  <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_last_rd <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // SRAM port: read strobe in RD_ACC, write in the same cycle as a W handshake.
  always_comb begin
    CEB = 1'b1;
    WEB = {AXI_STRB_BITS{1'b1}};
    A   = w_addr;
    DI  = {DATA_W{1'b0}};
    case (r_state)
      RD_ACC: CEB = 1'b0;
      WR_DATA: begin
        if (WVALID) begin
          CEB = 1'b0;
          WEB = ~WSTRB;
          DI  = WDATA;
        end else begin
          CEB = 1'b1;
        end
      end
      default: CEB = 1'b1;
    endcase
  end

  assign AWREADY = w_aw_grant;
  assign ARREADY = w_ar_grant;
  assign WREADY  = (r_state == WR_DATA);
  assign BID     = r_id;
  assign BRESP   = r_bresp;
  assign BVALID  = r_bvalid;
  assign RID     = r_id;
  assign RDATA   = r_rdata;
  assign RRESP   = RESP_OKAY;
  assign RLAST   = r_rlast;
  assign RVALID  = r_rvalid;

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a behavioural SRAM and a shadow of
// the expected memory contents.
module tb_sram_axi_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        CEB;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] DO;

  logic [31:0] mem    [0:16383];
  logic [31:0] shadow [0:16383];
  int n_checks = 0;
  int n_fail   = 0;

  sram_axi_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  always #5 ACLK = ~ACLK;

  // Single-port SRAM: one-cycle read latency, byte-enabled writes.
  always @(posedge ACLK) begin
    if (!CEB) begin
      if (WEB == 4'hF) begin
        DO <= mem[A];
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!WEB[k]) mem[A][k*8 +: 8] <= DI[k*8 +: 8];
        end
      end
    end
  end

  function automatic logic [31:0] pat(input logic [13:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                            input logic [1:0] burst, input bit toggle, input bit both);
    logic [13:0] a;
    int lat;
    ARADDR = addr; ARLEN = len; ARID = id; ARBURST = burst; ARSIZE = 3'd2;
    ARVALID = 1'b1;
    if (both) AWVALID = 1'b1;
    RREADY = 1'b1;
    #1;
    check_eq("arready", {63'd0, ARREADY}, 64'd1);
    if (both) check_eq("awready_lose", {63'd0, AWREADY}, 64'd0);
    tick();
    ARVALID = 1'b0;
    AWVALID = 1'b0;
    a = addr[15:2];
    for (int b = 0; b <= int'(len); b++) begin
      check_eq("r_ceb", {63'd0, CEB}, 64'd0);
      check_eq("r_addr", {50'd0, A}, {50'd0, a});
      check_eq("r_web", {60'd0, WEB}, 64'hF);
      lat = 0;
      while (!RVALID && lat < 8) begin
        tick();
        lat++;
      end
      check_eq("r_latency", 64'(lat), 64'd2);
      check_eq("r_data", {32'd0, RDATA}, {32'd0, shadow[a]});
      check_eq("r_last", {63'd0, RLAST}, {63'd0, (b == int'(len))});
      check_eq("r_id", {56'd0, RID}, {56'd0, id});
      check_eq("r_resp", {62'd0, RRESP}, 64'd0);
      if (toggle && (b % 2 == 0)) begin
        RREADY = 1'b0;
        tick();
        check_eq("r_stall_valid", {63'd0, RVALID}, 64'd1);
        check_eq("r_stall_data", {32'd0, RDATA}, {32'd0, shadow[a]});
        RREADY = 1'b1;
      end
      tick();
      if (burst != 2'b00) a = a + 14'd1;
    end
    check_eq("r_done", {63'd0, RVALID}, 64'd0);
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                             input int wlast_at, input int strb_beat, input logic [3:0] strb_val,
                             input int stall, input logic [1:0] exp_bresp, input bit both);
    logic [13:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    AWADDR = addr; AWLEN = len; AWID = id; AWBURST = 2'b01; AWSIZE = 3'd2;
    AWVALID = 1'b1;
    if (both) ARVALID = 1'b1;
    BREADY = 1'b0;
    #1;
    check_eq("awready", {63'd0, AWREADY}, 64'd1);
    if (both) check_eq("arready_lose", {63'd0, ARREADY}, 64'd0);
    tick();
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    a = addr[15:2];
    for (int b = 0; b <= int'(len); b++) begin
      wd = 32'h1111_1111 * 32'(b + 1);
      st = (b == strb_beat) ? strb_val : 4'hF;
      WDATA = wd; WSTRB = st; WLAST = (b == wlast_at); WVALID = 1'b1;
      #1;
      check_eq("w_ready", {63'd0, WREADY}, 64'd1);
      check_eq("w_ceb", {63'd0, CEB}, 64'd0);
      check_eq("w_addr", {50'd0, A}, {50'd0, a});
      check_eq("w_web", {60'd0, WEB}, {60'd0, ~st});
      check_eq("w_di", {32'd0, DI}, {32'd0, wd});
      for (int k = 0; k < 4; k++) begin
        if (st[k]) shadow[a][k*8 +: 8] = wd[k*8 +: 8];
      end
      tick();
      WVALID = 1'b0;
      WLAST = 1'b0;
      a = a + 14'd1;
    end
    check_eq("b_ceb_idle", {63'd0, CEB}, 64'd1);
    for (int s = 0; s < stall; s++) begin
      check_eq("b_valid_held", {63'd0, BVALID}, 64'd1);
      tick();
    end
    check_eq("b_valid", {63'd0, BVALID}, 64'd1);
    check_eq("b_id", {56'd0, BID}, {56'd0, id});
    check_eq("b_resp", {62'd0, BRESP}, {62'd0, exp_bresp});
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check_eq("b_done", {63'd0, BVALID}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ceb"}, {63'd0, CEB}, 64'd1);
    check_eq({tag, "_web"}, {60'd0, WEB}, 64'hF);
    check_eq({tag, "_a"}, {50'd0, A}, 64'd0);
    check_eq({tag, "_di"}, {32'd0, DI}, 64'd0);
    check_eq({tag, "_rvalid"}, {63'd0, RVALID}, 64'd0);
    check_eq({tag, "_rdata"}, {32'd0, RDATA}, 64'd0);
    check_eq({tag, "_rlast"}, {63'd0, RLAST}, 64'd0);
    check_eq({tag, "_rid"}, {56'd0, RID}, 64'd0);
    check_eq({tag, "_bvalid"}, {63'd0, BVALID}, 64'd0);
    check_eq({tag, "_bresp"}, {62'd0, BRESP}, 64'd0);
    check_eq({tag, "_arready"}, {63'd0, ARREADY}, 64'd0);
    check_eq({tag, "_awready"}, {63'd0, AWREADY}, 64'd0);
    check_eq({tag, "_wready"}, {63'd0, WREADY}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int seen;
    int cyc;
    for (int i = 0; i < 16384; i++) begin
      mem[i]    = pat(14'(i));
      shadow[i] = pat(14'(i));
    end
    ARESETn = 1'b0;
    AWID = 8'h00; AWADDR = 32'h0; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = 32'h0; WSTRB = 4'h0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = 8'h00; ARADDR = 32'h0; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
    RREADY = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    ARESETn = 1'b1;
    tick();

    // Single-beat read of word 4.
    read_burst(32'h0000_0010, 4'd0, 8'h12, 2'b01, 1'b0, 1'b0);
    // INCR write at 0x20, narrow strobe on the second beat.
    write_burst(32'h0000_0020, 4'd3, 8'h34, 3, 1, 4'b0011, 0, 2'b00, 1'b0);
    check_eq("mem8", {32'd0, mem[8]}, 64'h1111_1111);
    check_eq("mem9_partial", {32'd0, mem[9]}, 64'hC0DE_2222);
    check_eq("mem11", {32'd0, mem[11]}, 64'h4444_4444);
    // Early WLAST on a two-beat burst, response back-pressured.
    write_burst(32'h0000_0100, 4'd1, 8'h45, 0, -1, 4'hF, 5, 2'b10, 1'b0);
    check_eq("mem41", {32'd0, mem[14'h41]}, 64'h2222_2222);
    // FIXED burst keeps re-reading the same word.
    read_burst(32'h0000_0140, 4'd2, 8'h21, 2'b00, 1'b0, 1'b0);

    // Arbitration from a fresh reset: R, W, R, W.
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    tick();
    AWADDR = 32'h0000_0400; AWLEN = 4'd0; AWID = 8'h71;
    read_burst(32'h0000_0300, 4'd0, 8'h70, 2'b01, 1'b0, 1'b1);
    write_burst(32'h0000_0400, 4'd0, 8'h71, 0, -1, 4'hF, 0, 2'b00, 1'b1);
    read_burst(32'h0000_0304, 4'd0, 8'h72, 2'b01, 1'b0, 1'b1);
    write_burst(32'h0000_0404, 4'd0, 8'h73, 0, -1, 4'hF, 0, 2'b00, 1'b1);

    // 16-beat read wrapping the word address, RREADY toggling.
    read_burst(32'h0000_FFFC, 4'd15, 8'h5A, 2'b01, 1'b1, 1'b0);

    // Reset while the third beat of an 8-beat read is presented.
    ARADDR = 32'h0000_0200; ARLEN = 4'd7; ARID = 8'h66; ARBURST = 2'b01;
    ARVALID = 1'b1;
    RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    seen = 0;
    cyc = 0;
    while (seen < 3 && cyc < 40) begin
      if (RVALID) seen++;
      if (seen < 3) tick();
      cyc++;
    end
    check_eq("rst_beat3_seen", 64'(seen), 64'd3);
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    tick();
    ARESETn = 1'b1;
    tick();
    tick();
    check_eq("no_r_after_reset", {63'd0, RVALID}, 64'd0);
    read_burst(32'h0000_0200, 4'd1, 8'h67, 2'b01, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
